wb_commit: RTL
==============

Name: wb_commit

Overview:
- Write-back/commit stage: the writer side of the 32-entry register file.
- Accepts completed instructions from MEM and formats load data (byte/half extraction, sign/zero extension).
- Drives the register file write port one cycle after acceptance.
- Keeps a per-register pending-write scoreboard, set by ID at issue and cleared at commit, so ID can stall on RAW hazards the register file's forwarding cannot cover.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter (max in-flight writes per register = 2^CNT_W-1).
- RET_W, 32, width of retired-instruction counter.

Ports:
- dclk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_i  in  1  global stall; blocks acceptance from MEM
- valid_MEM_i  in  1  MEM presents an instruction
- ready_MEM_o  out  1  acceptance; equals !stall_i
- we_MEM_i  in  1  instruction writes rd
- waddr_MEM_i  in  5  rd
- wdata_MEM_i  in  32  ALU/non-load result
- sb_MEM_i  in  1  instruction incremented the scoreboard at issue
- is_load_MEM_i  in  1  select formatted load data instead of wdata_MEM_i
- ldtype_MEM_i  in  3  funct3 of the load
- laddr_lo_MEM_i  in  2  load address bits [1:0]
- ldword_MEM_i  in  32  aligned 32-bit word read from memory
- we_REG_o  out  1  register file write enable
- waddr_REG_o  out  5  register file write address
- wdata_REG_o  out  32  register file write data
- issue_ID_i  in  1  ID issues an instruction writing issue_rd_ID_i
- issue_rd_ID_i  in  5  rd of the issuing instruction
- sb_full_ID_o  out  1  counter of issue_rd_ID_i is at maximum; ID must not issue
- rs1_ID_i  in  5  source register 1 query
- rs2_ID_i  in  5  source register 2 query
- rs1_busy_ID_o  out  1  rs1 has an uncommitted pending write
- rs2_busy_ID_o  out  1  rs2 has an uncommitted pending write
- retired_o  out  RET_W  count of committed instructions

Behaviour:
- Reset: we_REG_o=0, waddr_REG_o=0, wdata_REG_o=0, the internal commit flag=0, all counters=0, retired_o=0. Reset mid-operation discards any held commit; a write-enable pulse pending at that edge is not produced.
- Accept: occurs at a dclk edge when valid_MEM_i & ready_MEM_o.
  - At that edge: we_REG_o <= we_MEM_i & (waddr_MEM_i!=0); waddr_REG_o <= waddr_MEM_i; wdata_REG_o <= formatted data; commit flag <= sb_MEM_i & (waddr_MEM_i!=0).
  - Any edge without an accept: we_REG_o <= 0 and commit flag <= 0, so every write is a single-cycle pulse. waddr_REG_o and wdata_REG_o hold.
- Latency: exactly 1 cycle from accept to write pulse. The register file samples at the following edge.
- Load formatting (is_load_MEM_i=1), using byte b = ldword[8*lo+7:8*lo]:
  - 000 LB: sext(b).
  - 100 LBU: zext(b).
  - 001 LH: sext(half at lo[1]); lo[0] is ignored.
  - 101 LHU: zext(half at lo[1]); lo[0] is ignored.
  - 010 LW: word.
  - Any other funct3: 0.
- Scoreboard, one counter per register 1..31; counter 0 is never changed.
  - Increment at an edge when issue_ID_i & issue_rd!=0.
  - Decrement at an edge when the commit flag=1, for waddr_REG_o.
  - Decrement happens even if we_MEM_i was 0, so squashed instructions still release their reservation.
  - Increment and decrement of the same register at the same edge: unchanged.
  - Saturates at max and does not wrap below 0.
  - Issue at max without a simultaneous decrement is a protocol error; the counter stays at max.
- sb_full_ID_o: combinational, 1 when count[issue_rd]==max and no decrement of that register occurs this cycle; 0 for rd=0.
- rsX_busy_ID_o: combinational.
  - 1 when count[rsX]>1.
  - 1 when count[rsX]==1 and not (commit flag & waddr_REG_o==rsX).
  - In the committing cycle the register file forwards wdata, so a count of 1 being released reads as not busy.
  - rsX=0 gives 0.
- retired_o: increments at each edge where the commit flag or we_REG_o is 1, i.e. once per accepted instruction with a write or scoreboard effect; wraps modulo 2^RET_W.

Test Plan:
- Reset, then accept ALU op rd=5, wdata=0x1234 with sb=1, after issuing rd=5 -> next cycle we_REG_o=1, waddr=5, wdata=0x1234. rs1=5 busy=1 before commit, 0 in commit cycle and after. we_REG_o returns to 0.
- Load word 0x80FF7F01, laddr_lo=3:
  - LB -> wdata=0xFFFFFF80
  - LBU -> 0x00000080
  - laddr_lo=2, LH -> 0xFFFF80FF
  - laddr_lo=0, LHU -> 0x00007F01
  - LW -> 0x80FF7F01
- Issue rd=7 three times -> sb_full_ID_o=1 for rd 7. Same-cycle issue rd=7 and commit rd=7 -> count stays 3, sb_full_ID_o=0 that cycle. Two more commits -> count 1, rs busy=1.
- Accept rd=0, we=1, sb=1 -> we_REG_o=0, no counter change, retired_o unchanged.
- stall_i=1 with valid_MEM_i=1 -> ready_MEM_o=0, no write pulse, counters unchanged. Release -> single pulse.
- Issue rd=9, accept its commit, assert rst in the commit cycle -> counters=0, we_REG_o=0 next cycle, retired_o=0.

Source files
------------

// File: rtl/wb_commit.sv
// Write-back/commit stage: formats load data, pulses the register file write port one cycle
// after acceptance, and tracks per-register pending writes for ID. Never backpressures except via stall_i.
module wb_commit #(
  parameter int CNT_W = 2,
  parameter int RET_W = 32
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             valid_MEM_i,
  output logic             ready_MEM_o,
  input  logic             we_MEM_i,
  input  logic [4:0]       waddr_MEM_i,
  input  logic [31:0]      wdata_MEM_i,
  input  logic             sb_MEM_i,
  input  logic             is_load_MEM_i,
  input  logic [2:0]       ldtype_MEM_i,
  input  logic [1:0]       laddr_lo_MEM_i,
  input  logic [31:0]      ldword_MEM_i,
  output logic             we_REG_o,
  output logic [4:0]       waddr_REG_o,
  output logic [31:0]      wdata_REG_o,
  input  logic             issue_ID_i,
  input  logic [4:0]       issue_rd_ID_i,
  output logic             sb_full_ID_o,
  input  logic [4:0]       rs1_ID_i,
  input  logic [4:0]       rs2_ID_i,
  output logic             rs1_busy_ID_o,
  output logic             rs2_busy_ID_o,
  output logic [RET_W-1:0] retired_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic        we;
    logic        commit;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t              wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [RET_W-1:0] retired_q, retired_d;

  logic        accept;
  logic        rd_nz;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic [31:0] wdata_fmt;

  assign ready_MEM_o = !stall_i;
  assign accept      = valid_MEM_i & !stall_i;
  assign rd_nz       = (waddr_MEM_i != 5'd0);

  always_comb begin
    ld_byte = 8'(ldword_MEM_i >> {laddr_lo_MEM_i, 3'b000});
    ld_half = laddr_lo_MEM_i[1] ? ldword_MEM_i[31:16] : ldword_MEM_i[15:0];
    case (ldtype_MEM_i)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      3'b010:  ld_fmt = ldword_MEM_i;
      default: ld_fmt = 32'd0;
    endcase
    wdata_fmt = is_load_MEM_i ? ld_fmt : wdata_MEM_i;
  end

  // Address/data hold between accepts; enables are single-cycle pulses.
  always_comb begin
    wb_d        = wb_q;
    wb_d.we     = 1'b0;
    wb_d.commit = 1'b0;
    if (accept) begin
      wb_d.we     = we_MEM_i & rd_nz;
      wb_d.commit = sb_MEM_i & rd_nz;
      wb_d.waddr  = waddr_MEM_i;
      wb_d.wdata  = wdata_fmt;
    end
  end

  // Simultaneous issue and commit to the same register cancel out.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      logic inc, dec;
      inc      = issue_ID_i && (issue_rd_ID_i == 5'(i)) && (i != 0);
      dec      = wb_q.commit && (wb_q.waddr == 5'(i)) && (i != 0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec && (cnt_q[i] != CNT_MAX))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec && !inc && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (wb_q.commit || wb_q.we)
      retired_d = retired_q + RET_W'(1);
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      wb_q      <= '0;
      retired_q <= '0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      wb_q      <= wb_d;
      retired_q <= retired_d;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic [CNT_W-1:0] cnt_issue, cnt_rs1, cnt_rs2;
  logic             rel_issue, rel_rs1, rel_rs2;

  assign cnt_issue = cnt_q[issue_rd_ID_i];
  assign cnt_rs1   = cnt_q[rs1_ID_i];
  assign cnt_rs2   = cnt_q[rs2_ID_i];
  assign rel_issue = wb_q.commit && (wb_q.waddr == issue_rd_ID_i);
  assign rel_rs1   = wb_q.commit && (wb_q.waddr == rs1_ID_i);
  assign rel_rs2   = wb_q.commit && (wb_q.waddr == rs2_ID_i);

  assign sb_full_ID_o = (issue_rd_ID_i != 5'd0) && (cnt_issue == CNT_MAX) && !rel_issue;

  // A last pending write being committed now is covered by register file forwarding.
  assign rs1_busy_ID_o = (rs1_ID_i != 5'd0) &&
                         ((cnt_rs1 > CNT_W'(1)) || ((cnt_rs1 == CNT_W'(1)) && !rel_rs1));
  assign rs2_busy_ID_o = (rs2_ID_i != 5'd0) &&
                         ((cnt_rs2 > CNT_W'(1)) || ((cnt_rs2 == CNT_W'(1)) && !rel_rs2));

  assign we_REG_o    = wb_q.we;
  assign waddr_REG_o = wb_q.waddr;
  assign wdata_REG_o = wb_q.wdata;
  assign retired_o   = retired_q;

endmodule
